// File: rtl/pc_fetch_unit_pkg.sv
// Shared defines for the fetch path: FSM encoding, reset PC, instruction fields, opcodes, ALU ops.
// Pure declarations, no latency or backpressure of its own.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [7:0]  DEF_WAIT_LIMIT = 8'd255;

    // Instruction field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int TGT_MSB   = 25;
    localparam int IMM_MSB   = 15;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_JR   = 6'h08,
        FN_JALR = 6'h09,
        FN_ADD  = 6'h20,
        FN_SUB  = 6'h22
    } funct_t;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_AND   = 3'd2,
        ALUOP_OR    = 3'd3,
        ALUOP_SLT   = 3'd4,
        ALUOP_FUNCT = 3'd5
    } aluop_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC select: jr/jalr, jump, taken branch, else sequential.
// Purely combinational; no backpressure.
module next_pc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0]      i_pc_plus4,
    input  logic [TGT_MSB:0] i_inst_idx,
    input  logic             i_jump,
    input  logic             i_jump_reg,
    input  logic             i_branch,
    input  logic             i_zero,
    input  logic             i_reverse,
    input  logic [31:0]      i_rs_data,
    output logic [31:0]      o_next_pc
);

    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    assign w_br_tgt = i_pc_plus4 + {{14{i_inst_idx[IMM_MSB]}}, i_inst_idx[IMM_MSB:0], 2'b00};
    assign w_j_tgt  = {i_pc_plus4[31:28], i_inst_idx, 2'b00};

    // Reverse flips the zero sense so one input serves both beq and bne
    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump_reg && i_jump) begin
            o_next_pc = i_rs_data;
        end else if (i_jump) begin
            o_next_pc = w_j_tgt;
        end else if (i_branch && (i_zero ^ i_reverse)) begin
            o_next_pc = w_br_tgt;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC/fetch sequencer: FETCH waits on MIO_ready (instruction valid 1 cycle later), EXEC holds on Mem_busy,
// HALT after fetch timeout until reset. Misaligned targets are truncated and flagged.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [7:0]  WAIT_LIMIT = DEF_WAIT_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MIO_ready,
    input  logic [31:0] Inst_in,
    input  logic        Mem_busy,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Branch,
    input  logic        Reverse,
    input  logic        Zero,
    input  logic [31:0] Rs_data,
    output logic        Inst_req,
    output logic [31:0] Inst_addr,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic [31:0] Inst_out,
    output logic        Inst_valid,
    output logic        Timeout,
    output logic        Misalign
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;
    logic        r_misalign;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_wait_expired;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_wait_expired = (r_wait_cnt == WAIT_LIMIT);

    next_pc_calc u_next_pc_calc (
        .i_pc_plus4 (w_pc_plus4),
        .i_inst_idx (r_inst[TGT_MSB:0]),
        .i_jump     (Jump),
        .i_jump_reg (JumpReg),
        .i_branch   (Branch),
        .i_zero     (Zero),
        .i_reverse  (Reverse),
        .i_rs_data  (Rs_data),
        .o_next_pc  (w_next_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (MIO_ready) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_wait_expired) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (!Mem_busy) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_inst     <= 32'd0;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH) begin
                if (MIO_ready) begin
                    r_inst     <= Inst_in;
                    r_wait_cnt <= 8'd0;
                end else if (w_wait_expired) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end
            if ((r_state == ST_EXEC) && !Mem_busy) begin
                r_pc <= {w_next_pc[31:2], 2'b00};
                if (w_next_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    // Request/valid are gated by rst so nothing is issued during the reset cycle
    assign Inst_req   = (r_state == ST_FETCH) && !rst;
    assign Inst_valid = (r_state == ST_EXEC) && !rst;
    assign Inst_addr  = r_pc;
    assign PC         = r_pc;
    assign PC_plus4   = w_pc_plus4;
    assign Inst_out   = r_inst;
    assign Timeout    = r_timeout;
    assign Misalign   = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written multi-cycle corners,
// and randomized instruction streams checked against a transaction-level PC model.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MIO_ready;
    logic [31:0] Inst_in;
    logic        Mem_busy;
    logic        Jump, JumpReg, Branch, Reverse, Zero;
    logic [31:0] Rs_data;
    logic        Inst_req;
    logic [31:0] Inst_addr, PC, PC_plus4, Inst_out;
    logic        Inst_valid, Timeout, Misalign;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    logic        exp_mis;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .MIO_ready  (MIO_ready),
        .Inst_in    (Inst_in),
        .Mem_busy   (Mem_busy),
        .Jump       (Jump),
        .JumpReg    (JumpReg),
        .Branch     (Branch),
        .Reverse    (Reverse),
        .Zero       (Zero),
        .Rs_data    (Rs_data),
        .Inst_req   (Inst_req),
        .Inst_addr  (Inst_addr),
        .PC         (PC),
        .PC_plus4   (PC_plus4),
        .Inst_out   (Inst_out),
        .Inst_valid (Inst_valid),
        .Timeout    (Timeout),
        .Misalign   (Misalign)
    );

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] inst;
        logic        j, jr, br, z, rev;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Architectural next-PC rule, returns {misalign, aligned_pc}
    function automatic logic [32:0] ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic j, input logic jr, input logic br,
                                             input logic z, input logic rev, input logic [31:0] rs);
        logic [31:0] pc4, t;
        logic [15:0] imm;
        int          simm;
        pc4  = pc + 32'd4;
        imm  = inst[15:0];
        simm = int'($signed(imm));
        if (j && jr)                 t = rs;
        else if (j)                  t = (pc4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
        else if (br && (z != rev))   t = pc4 + 32'(simm * 4);
        else                         t = pc4;
        return {(t[1:0] != 2'b00), t & 32'hFFFF_FFFC};
    endfunction

    task automatic clear_ctrl();
        Jump = 0; JumpReg = 0; Branch = 0; Reverse = 0; Zero = 0; Rs_data = 0; Mem_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1; MIO_ready = 0; Inst_in = 0;
        clear_ctrl();
        step();
        #1;
        chk("rst_req", Inst_req, 0);
        chk("rst_valid", Inst_valid, 0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_inst", Inst_out, 32'h0);
        chk("rst_timeout", Timeout, 0);
        chk("rst_misalign", Misalign, 0);
        rst = 0;
        #1;
        chk("rst_release_req", Inst_req, 1);
        exp_pc  = 32'h0;
        exp_mis = 0;
    endtask

    // One instruction: wait_cyc idle fetch cycles, ready, then busy_cyc stalled EXEC cycles
    task automatic run_instr(input logic [31:0] inst, input int wait_cyc, input int busy_cyc,
                             input logic j, input logic jr, input logic br, input logic z,
                             input logic rev, input logic [31:0] rs);
        logic [32:0] r;
        for (int i = 0; i < wait_cyc; i++) begin
            MIO_ready = 0; Inst_in = $urandom;
            #1;
            chk("fetch_wait_req", Inst_req, 1);
            step();
        end
        MIO_ready = 1; Inst_in = inst;
        #1;
        chk("fetch_req", Inst_req, 1);
        chk("fetch_addr", Inst_addr, exp_pc);
        step();
        Jump = j; JumpReg = jr; Branch = br; Zero = z; Reverse = rev; Rs_data = rs;
        for (int i = 0; i <= busy_cyc; i++) begin
            Mem_busy  = (i < busy_cyc);
            MIO_ready = 1'($urandom);
            Inst_in   = $urandom;
            #1;
            chk("exec_valid", Inst_valid, 1);
            chk("exec_req", Inst_req, 0);
            chk("exec_pc", PC, exp_pc);
            chk("exec_pc4", PC_plus4, exp_pc + 32'd4);
            chk("exec_inst", Inst_out, inst);
            step();
        end
        MIO_ready = 0;
        clear_ctrl();
        r       = ref_next(exp_pc, inst, j, jr, br, z, rev, rs);
        exp_pc  = r[31:0];
        exp_mis = exp_mis | r[32];
        #1;
        chk("next_pc", PC, exp_pc);
        chk("misalign", Misalign, exp_mis);
        chk("back_valid", Inst_valid, 0);
        chk("back_req", Inst_req, 1);
        chk("no_timeout", Timeout, 0);
    endtask

    initial begin
        int reqcnt;
        logic [31:0] halt_pc;

        rst = 1; MIO_ready = 0; Inst_in = 0;
        clear_ctrl();

        vecs[0]  = '{32'h0000_0000, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_003C, 1'b0};
        vecs[2]  = '{32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0000_0044, 1'b0};
        vecs[3]  = '{32'h0000_0040, 32'h1400_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_003C, 1'b0};
        vecs[4]  = '{32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0044, 1'b0};
        vecs[5]  = '{32'h1000_0010, 32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_0400, 1'b0};
        vecs[6]  = '{32'h1000_0010, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2002, 32'h0000_2000, 1'b1};
        vecs[7]  = '{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[8]  = '{32'hFFFF_FFF0, 32'h1000_0004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[9]  = '{32'h0000_0100, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5554, 32'h0000_0104, 1'b0};
        vecs[10] = '{32'h0000_0080, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0FFF_FFFC, 1'b0};
        vecs[11] = '{32'h0000_0020, 32'h0000_0009, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0000, 1'b1};

        // Reset, one idle cycle, then ready: addi executes and PC goes 0 -> 4
        do_reset();
        MIO_ready = 0;
        #1;
        chk("first_req", Inst_req, 1);
        step();
        MIO_ready = 1; Inst_in = 32'h2008_0005;
        step();
        MIO_ready = 0;
        #1;
        chk("first_exec_valid", Inst_valid, 1);
        chk("first_exec_req", Inst_req, 0);
        chk("first_op", Inst_out[OP_MSB:OP_LSB], OP_ADDI);
        chk("first_funct", Inst_out[FUNCT_MSB:FUNCT_LSB], 32'h05);
        step();
        #1;
        chk("first_pc", PC, 32'h4);

        // Directed next-PC vectors, each from a fresh reset and a jr to start_pc
        for (int k = 0; k < 12; k++) begin
            do_reset();
            run_instr(32'h0000_0008, 1, 0, 1, 1, 0, 0, 0, vecs[k].start_pc);
            chk("vec_start_pc", PC, vecs[k].start_pc);
            run_instr(vecs[k].inst, $urandom_range(0, 3), 0, vecs[k].j, vecs[k].jr, vecs[k].br,
                      vecs[k].z, vecs[k].rev, vecs[k].rs);
            chk("vec_pc", PC, vecs[k].exp_pc);
            chk("vec_misalign", Misalign, vecs[k].exp_mis);
        end

        // Mem_busy for 3 cycles: Inst_valid for 4 cycles with PC held
        do_reset();
        MIO_ready = 1; Inst_in = 32'h2008_0001;
        step();
        MIO_ready = 0;
        reqcnt = 0;
        for (int i = 0; i < 6; i++) begin
            Mem_busy = (i < 3);
            #1;
            if (Inst_valid) reqcnt++;
            if (i < 4) chk("busy_pc_hold", PC, 32'h0);
            step();
        end
        Mem_busy = 0;
        chk("busy_valid_cycles", reqcnt, 4);

        // MIO_ready arriving exactly as the wait counter hits the limit wins
        do_reset();
        run_instr(32'h2008_0002, 255, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("limit_ready_pc", PC, 32'h4);

        // Reset with same-cycle MIO_ready discards the data
        do_reset();
        rst = 1; MIO_ready = 1; Inst_in = 32'hDEAD_BEEF;
        #1;
        chk("midrst_req", Inst_req, 0);
        step();
        rst = 0; MIO_ready = 0;
        #1;
        chk("midrst_inst", Inst_out, 32'h0);
        chk("midrst_valid", Inst_valid, 0);
        chk("midrst_req_after", Inst_req, 1);

        // Reset taken while stalled in EXEC
        MIO_ready = 1; Inst_in = 32'h1234_5678;
        step();
        MIO_ready = 0; Mem_busy = 1;
        #1;
        chk("exec_before_rst", Inst_valid, 1);
        rst = 1;
        step();
        rst = 0; Mem_busy = 0;
        #1;
        chk("exec_rst_valid", Inst_valid, 0);
        chk("exec_rst_inst", Inst_out, 32'h0);
        chk("exec_rst_req", Inst_req, 1);

        // 256 fetch cycles without MIO_ready: timeout and HALT
        do_reset();
        run_instr(32'h0000_0008, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0800);
        halt_pc = PC;
        reqcnt = 0;
        MIO_ready = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (Inst_req) reqcnt++;
            chk("pre_timeout_flag", Timeout, 0);
            step();
        end
        #1;
        chk("timeout_req_cycles", reqcnt, 256);
        chk("timeout_flag", Timeout, 1);
        chk("halt_req", Inst_req, 0);
        chk("halt_valid", Inst_valid, 0);
        MIO_ready = 1; Inst_in = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("halt_req_hold", Inst_req, 0);
            chk("halt_valid_hold", Inst_valid, 0);
            chk("halt_pc_hold", PC, halt_pc);
            chk("halt_inst_hold", Inst_out, 32'h0000_0008);
        end
        do_reset();

        // Randomized instruction streams against the model
        for (int n = 0; n < 250; n++) begin
            logic [31:0] rs;
            int          w;
            if ((n % 50) == 0) do_reset();
            rs = $urandom;
            if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
            w = ($urandom_range(0, 40) == 0) ? 255 : int'($urandom_range(0, 6));
            run_instr($urandom, w, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
